// File: rtl/eth_rx_fcs_check.sv
// Ethernet receive FCS checker: runs CRC-32 over every frame byte, strips the 4 FCS bytes through
// a 4-deep delay line and flags bad frames on the final payload beat.
module eth_rx_fcs_check #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MIN_FRAME  = 64,
  parameter int unsigned MAX_FRAME  = 1518,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  mac_clk,
  input  logic                  mac_rst_n,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_error,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_error,
  output logic [CNT_WIDTH-1:0]  good_frames,
  output logic [CNT_WIDTH-1:0]  bad_frames
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam int unsigned   LW      = $clog2(MAX_FRAME + 2);
  localparam logic [LW-1:0] LEN_MIN = LW'(MIN_FRAME);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_FRAME);
  localparam logic [LW-1:0] LEN_SAT = LW'(MAX_FRAME + 1);

  // Reflected CRC-32, data consumed LSB first.
  function automatic logic [31:0] crc_update(input logic [31:0]           crc,
                                             input logic [DATA_WIDTH-1:0] data);
    logic [31:0] c;
    c = crc ^ {{(32 - DATA_WIDTH){1'b0}}, data};
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  logic [1:0]                 state_q, state_d;
  logic [3:0][DATA_WIDTH-1:0] dly_q, dly_d;
  logic                       first_q, first_d;
  logic [31:0]                crc_q, crc_d;
  logic [LW-1:0]              len_q, len_d;
  logic                       sticky_q, sticky_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_sop_q, out_sop_d;
  logic                       out_eop_q, out_eop_d;
  logic                       out_err_q, out_err_d;
  logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]       good_q, good_d;
  logic [CNT_WIDTH-1:0]       bad_q, bad_d;
  logic                       good_inc;
  logic [1:0]                 bad_inc;
  logic                       frame_bad;

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    first_d     = first_q;
    crc_d       = crc_q;
    len_d       = len_q;
    sticky_d    = sticky_q;
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    out_err_d   = 1'b0;
    out_data_d  = out_data_q;
    good_inc    = 1'b0;
    bad_inc     = 2'd0;
    frame_bad   = 1'b0;

    if (in_valid && (in_startofpacket || state_q != S_IDLE)) begin
      dly_d = {dly_q[2:0], in_data};
      if (in_startofpacket) begin
        // A sop inside a frame aborts it; close it only if its first beat already left.
        if (state_q != S_IDLE) begin
          bad_inc = 2'd1;
          if (state_q == S_PASS && !first_q) begin
            out_valid_d = 1'b1;
            out_data_d  = dly_q[3];
            out_eop_d   = 1'b1;
            out_err_d   = 1'b1;
          end
        end
        crc_d    = crc_update(CRC_INIT, in_data);
        len_d    = LW'(1);
        sticky_d = in_error;
        first_d  = 1'b1;
        state_d  = S_FILL;
      end else begin
        crc_d    = crc_update(crc_q, in_data);
        len_d    = (len_q == LEN_SAT) ? LEN_SAT : len_q + LW'(1);
        sticky_d = sticky_q | in_error;
        if (state_q == S_PASS) begin
          out_valid_d = 1'b1;
          out_data_d  = dly_q[3];
          out_sop_d   = first_q;
          first_d     = 1'b0;
        end else if (len_q == LW'(3)) begin
          state_d = S_PASS;
        end
      end

      if (in_endofpacket) begin
        frame_bad = sticky_d | (crc_d != CRC_RESIDUE) | (len_d < LEN_MIN) | (len_d > LEN_MAX);
        if (!in_startofpacket && state_q == S_PASS) begin
          out_eop_d = 1'b1;
          out_err_d = frame_bad;
          good_inc  = ~frame_bad;
          bad_inc   = {1'b0, frame_bad};
        end else begin
          // Frames of four bytes or fewer never reach the output.
          bad_inc = bad_inc + 2'd1;
        end
        state_d  = S_IDLE;
        crc_d    = CRC_INIT;
        len_d    = '0;
        sticky_d = 1'b0;
        first_d  = 1'b1;
      end
    end

    good_d = good_q + CNT_WIDTH'(good_inc);
    bad_d  = bad_q + CNT_WIDTH'(bad_inc);
  end

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      state_q     <= S_IDLE;
      dly_q       <= '0;
      first_q     <= 1'b1;
      crc_q       <= CRC_INIT;
      len_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
      good_q      <= '0;
      bad_q       <= '0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      first_q     <= first_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_err_q   <= out_err_d;
      out_data_q  <= out_data_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_error         = out_err_q;
  assign out_data          = out_data_q;
  assign good_frames       = good_q;
  assign bad_frames        = bad_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: frames are built with a bench-side FCS generator and the
// collected output beats are compared against the bytes that were sent.
module tb_eth_rx_fcs_check;

  logic        mac_clk = 1'b0;
  logic        mac_rst_n = 1'b0;
  logic        in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0, in_err = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_sop, out_eop, out_valid, out_err;
  logic [7:0]  out_data;
  logic [31:0] good_frames, bad_frames;

  always #5 mac_clk = ~mac_clk;

  eth_rx_fcs_check #(
    .DATA_WIDTH(8),
    .MIN_FRAME (64),
    .MAX_FRAME (1518),
    .CNT_WIDTH (32)
  ) dut (
    .mac_clk          (mac_clk),
    .mac_rst_n        (mac_rst_n),
    .in_startofpacket (in_sop),
    .in_endofpacket   (in_eop),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_error         (in_err),
    .out_startofpacket(out_sop),
    .out_endofpacket  (out_eop),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_error        (out_err),
    .good_frames      (good_frames),
    .bad_frames       (bad_frames)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  d;
    logic        s;
    logic        e;
    logic        r;
  } beat_t;

  beat_t       beats[$];
  logic [7:0]  frm[$];
  logic [7:0]  frm_a[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          viol = 0;
  logic [31:0] cyc = 0;
  logic [31:0] acc4 = 0;

  always @(posedge mac_clk) cyc <= cyc + 1;

  always @(negedge mac_clk) begin
    if (out_valid) begin
      beats.push_back({cyc, out_data, out_sop, out_eop, out_err});
      if (out_err && !out_eop) viol <= viol + 1;
    end else if (out_sop || out_eop || out_err) begin
      viol <= viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] d, input logic s, input logic e, input logic r);
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_err   = r;
    @(posedge mac_clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_err   = 1'b0;
    repeat (n) begin
      @(posedge mac_clk);
      #1;
    end
  endtask

  // Bit-serial reference CRC-32 used only to produce the FCS of each stimulus frame.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB8_8320;
    end
    return c;
  endfunction

  task automatic build(input int npl, input logic [7:0] base);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    frm.delete();
    for (int i = 0; i < npl; i++) begin
      frm.push_back(base + 8'(i));
      c = crc_byte(c, frm[i]);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic send(input int err_idx, input int gap_after, input bit with_eop);
    for (int i = 0; i < frm.size(); i++) begin
      put(frm[i], i == 0, with_eop && (i == frm.size() - 1), i == err_idx);
      if (i == 4) acc4 = cyc;
      if (i == gap_after) begin
        for (int g = 0; g < 3; g++) begin
          idle(1);
          chk("gap_stall", out_valid, 0);
        end
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_err   = 1'b0;
  endtask

  // beats[first +: nb] must carry frm[0 +: nb], sop on the first, eop (+ exp_err) on the last.
  task automatic check_frame(input string tag, input int first, input int nb, input logic exp_err);
    int mism;
    mism = 0;
    chk({tag, "_nbeats"}, 64'(beats.size()), 64'(first + nb));
    for (int i = 0; i < nb; i++) begin
      if (first + i >= int'(beats.size())) mism++;
      else if (beats[first+i].d !== frm[i] || beats[first+i].s !== (i == 0) ||
               beats[first+i].e !== (i == nb - 1) ||
               beats[first+i].r !== ((i == nb - 1) && exp_err)) mism++;
    end
    chk({tag, "_beat_fields"}, mism, 0);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", {out_sop, out_eop, out_err}, 0);
    chk("rst_good", good_frames, 0);
    chk("rst_bad", bad_frames, 0);
    @(posedge mac_clk);
    #1;
    mac_rst_n = 1'b1;
    idle(2);

    // Good 64-byte frame.
    beats.delete();
    build(60, 8'h00);
    send(-1, -1, 1'b1);
    idle(3);
    check_frame("good64", 0, 60, 1'b0);
    chk("good64_latency", (beats.size() > 0) ? beats[0].cyc : 32'hFFFF_FFFF, acc4);
    chk("good64_good", good_frames, 1);
    chk("good64_bad", bad_frames, 0);

    // Corrupted payload byte 10.
    beats.delete();
    build(60, 8'h00);
    frm[10] = frm[10] ^ 8'h01;
    send(-1, -1, 1'b1);
    idle(3);
    check_frame("badfcs", 0, 60, 1'b1);
    chk("badfcs_good", good_frames, 1);
    chk("badfcs_bad", bad_frames, 1);

    // Runt: 60 bytes with valid FCS.
    beats.delete();
    build(56, 8'h10);
    send(-1, -1, 1'b1);
    idle(3);
    check_frame("runt", 0, 56, 1'b1);
    chk("runt_bad", bad_frames, 2);

    // Oversize: 1519 bytes with valid FCS.
    beats.delete();
    build(1515, 8'h00);
    send(-1, -1, 1'b1);
    idle(3);
    check_frame("oversize", 0, 1515, 1'b1);
    chk("oversize_bad", bad_frames, 3);

    // PHY error on byte 20 plus a 3-cycle valid gap after byte 30.
    beats.delete();
    build(60, 8'h20);
    send(20, 30, 1'b1);
    idle(3);
    check_frame("phyerr", 0, 60, 1'b1);
    chk("phyerr_bad", bad_frames, 4);
    chk("phyerr_good", good_frames, 1);

    // 5-byte frame: single beat with sop and eop.
    beats.delete();
    build(1, 8'h5A);
    send(-1, -1, 1'b1);
    idle(3);
    check_frame("five", 0, 1, 1'b1);
    chk("five_bad", bad_frames, 5);

    // Frame A (20 bytes, no eop) aborted by frame B's sop.
    beats.delete();
    build(16, 8'h40);
    frm_a = frm;
    send(-1, -1, 1'b0);
    build(60, 8'h80);
    send(-1, -1, 1'b1);
    idle(3);
    begin
      int mism;
      mism = 0;
      for (int i = 0; i < 17; i++) begin
        if (i >= int'(beats.size())) mism++;
        else if (beats[i].d !== frm_a[i] || beats[i].s !== (i == 0) ||
                 beats[i].e !== (i == 16) || beats[i].r !== (i == 16)) mism++;
      end
      chk("abort_a_beats", mism, 0);
    end
    check_frame("abort_b", 17, 60, 1'b0);
    chk("abort_good", good_frames, 2);
    chk("abort_bad", bad_frames, 6);

    // 3-byte frame: dropped, counted bad.
    beats.delete();
    frm.delete();
    frm.push_back(8'h01);
    frm.push_back(8'h02);
    frm.push_back(8'h03);
    send(-1, -1, 1'b1);
    idle(3);
    chk("tiny_nbeats", beats.size(), 0);
    chk("tiny_bad", bad_frames, 7);

    // Reset mid-frame, then a good frame.
    build(60, 8'h00);
    while (frm.size() > 30) void'(frm.pop_back());
    send(-1, -1, 1'b0);
    chk("prerst_valid", out_valid, 1);
    mac_rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_good", good_frames, 0);
    chk("midrst_bad", bad_frames, 0);
    @(posedge mac_clk);
    #1;
    mac_rst_n = 1'b1;
    idle(2);
    beats.delete();
    build(60, 8'h33);
    send(-1, -1, 1'b1);
    idle(3);
    check_frame("postrst", 0, 60, 1'b0);
    chk("postrst_good", good_frames, 1);
    chk("postrst_bad", bad_frames, 0);

    chk("idle_flags", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
